// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter with in-order read return routing
// Optional requester-1 bus lock: MEM_ARB_LOCK_EN
module mem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RD_LAT    = 2,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    input  logic          lock1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    logic              last_owner;
    logic [3:0]        burst_cnt;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_id;
    logic              lock_hold;
    logic              xfer0;
    logic              xfer1;

`ifdef MEM_ARB_LOCK_EN
    assign lock_hold = lock1 & last_owner;
`else
    logic unused_lock;
    assign lock_hold   = 1'b0;
    assign unused_lock = lock1;
`endif

    // Grants are suppressed during reset so nothing is reported as accepted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (CLB) begin
            if (lock_hold) begin
                gnt1 = req1;
            end else if (req0 && req1) begin
                if (burst_cnt == BURST_LIM) gnt1 = 1'b1;
                else                        gnt0 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign xfer0 = req0 & gnt0;
    assign xfer1 = req1 & gnt1;

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_owner <= 1'b0;
            burst_cnt  <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
        end else begin
            if (xfer0 || xfer1) begin
                mem_en     <= 1'b1;
                mem_we     <= xfer1 ? we1    : we0;
                mem_addr   <= xfer1 ? addr1  : addr0;
                mem_wdata  <= xfer1 ? wdata1 : wdata0;
                last_owner <= xfer1;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            if (!req1 || xfer1 || lock_hold) begin
                burst_cnt <= '0;
            end else if (xfer0 && burst_cnt != BURST_LIM) begin
                burst_cnt <= burst_cnt + 4'd1;
            end

            // last_owner names the requester of the command currently on the bus.
            tag_v[0]  <= mem_en & ~mem_we;
            tag_id[0] <= last_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign rvalid0 = tag_v[RD_LAT-1] & ~tag_id[RD_LAT-1];
    assign rvalid1 = tag_v[RD_LAT-1] &  tag_id[RD_LAT-1];
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (table vectors plus reset and lock sequences)
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       CLB;
    logic       req0, we0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .CLB(CLB),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .lock1(lock1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory macro with two cycles of read latency.
    logic [7:0] mem [256];
    logic [7:0] rd_pipe;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe   <= (mem_en && !mem_we) ? mem[mem_addr] : 8'h00;
        mem_rdata <= rd_pipe;
    end

    typedef struct {
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       g0, g1, en, we;
        logic [7:0] addr;
        logic       v0;
        logic [7:0] q0;
        logic       v1;
        logic [7:0] q1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r0, w0, input logic [7:0] a0, d0,
                       input logic r1, w1, input logic [7:0] a1, d1,
                       input logic g0, g1, en, we, input logic [7:0] addr,
                       input logic v0, input logic [7:0] q0,
                       input logic v1, input logic [7:0] q1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.en = en; v.we = we; v.addr = addr;
        v.v0 = v0; v.q0 = q0; v.v1 = v1; v.q1 = q1;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, w0, input logic [7:0] a0, d0,
                         input logic r1, w1, input logic [7:0] a1, d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5; mem[8'h40] = 8'hC4; mem[8'h50] = 8'hD5;
        mem[8'h01] = 8'h11; mem[8'h02] = 8'h22; mem[8'h03] = 8'h33;

        // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 en we addr | v0 q0 v1 q1
        add(1,0,8'h10,0, 0,0,0,0,          1,0, 0,0,8'h00, 0,0,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 1,0,8'h10, 0,0,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h10, 0,0,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h10, 1,8'hA5,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h10, 0,0,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 0,0,8'h10, 0,0,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 1,0,8'h40, 0,0,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 1,0,8'h40, 0,0,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 1,0,8'h40, 1,8'hC4,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      0,1, 1,0,8'h40, 1,8'hC4,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 1,0,8'h50, 1,8'hC4,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 1,0,8'h40, 1,8'hC4,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 1,0,8'h40, 0,0,1,8'hD5);
        add(1,0,8'h40,0, 1,0,8'h50,0,      1,0, 1,0,8'h40, 1,8'hC4,0,0);
        add(1,0,8'h40,0, 1,0,8'h50,0,      0,1, 1,0,8'h40, 1,8'hC4,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 1,0,8'h50, 1,8'hC4,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h50, 1,8'hC4,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h50, 0,0,1,8'hD5);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h50, 0,0,0,0);
        add(0,0,0,0,     1,1,8'h20,8'h3C,  0,1, 0,0,8'h50, 0,0,0,0);
        add(1,0,8'h20,0, 0,0,0,0,          1,0, 1,1,8'h20, 0,0,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 1,0,8'h20, 0,0,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h20, 0,0,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h20, 1,8'h3C,0,0);
        add(1,0,8'h01,0, 0,0,0,0,          1,0, 0,0,8'h20, 0,0,0,0);
        add(0,0,0,0,     1,0,8'h02,0,      0,1, 1,0,8'h01, 0,0,0,0);
        add(1,0,8'h03,0, 0,0,0,0,          1,0, 1,0,8'h02, 0,0,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 1,0,8'h03, 1,8'h11,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h03, 0,0,1,8'h22);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h03, 1,8'h33,0,0);
        add(0,0,0,0,     0,0,0,0,          0,0, 0,0,8'h03, 0,0,0,0);

        // Reset state, with both requesters asking.
        CLB = 1'b0; lock1 = 1'b0;
        drive(1,0,8'h10,8'h00, 1,0,8'h50,8'h00);
        repeat (3) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);         chk("rst_gnt1", gnt1, 0);
        chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid0", rvalid0, 0);   chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata0", rdata0, 0);     chk("rst_rdata1", rdata1, 0);
        next_cycle();
        CLB = 1'b1;
        drive(0,0,0,0, 0,0,0,0);

        foreach (tbl[i]) begin
            next_cycle();
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), gnt0, tbl[i].g0);
            chk($sformatf("v%0d_gnt1", i), gnt1, tbl[i].g1);
            chk($sformatf("v%0d_mem_en", i), mem_en, tbl[i].en);
            if (tbl[i].en) chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].we);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("v%0d_rvalid0", i), rvalid0, tbl[i].v0);
            chk($sformatf("v%0d_rdata0", i), rdata0, tbl[i].q0);
            chk($sformatf("v%0d_rvalid1", i), rvalid1, tbl[i].v1);
            chk($sformatf("v%0d_rdata1", i), rdata1, tbl[i].q1);
        end

        // Two reads in flight, then reset pulsed mid-cycle.
        next_cycle(); drive(1,0,8'h10,0, 0,0,0,0);
        next_cycle(); drive(0,0,0,0, 1,0,8'h02,0);
        next_cycle(); drive(1,0,8'h40,0, 1,0,8'h50,0);
        #2 CLB = 1'b0;
        #1;
        chk("mid_rst_gnt0", gnt0, 0);         chk("mid_rst_gnt1", gnt1, 0);
        chk("mid_rst_mem_en", mem_en, 0);     chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_rvalid0", rvalid0, 0);   chk("mid_rst_rvalid1", rvalid1, 0);
        next_cycle();
        CLB = 1'b1;
        drive(0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_rvalid0", i), rvalid0, 0);
            chk($sformatf("post_rst%0d_rvalid1", i), rvalid1, 0);
            chk($sformatf("post_rst%0d_mem_en", i), mem_en, 0);
            next_cycle();
        end
        drive(1,0,8'h10,0, 0,0,0,0);
        @(negedge clk); chk("post_rst_read_gnt0", gnt0, 1);
        next_cycle(); drive(0,0,0,0, 0,0,0,0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("post_rst_read_rvalid0", rvalid0, 1);
        chk("post_rst_read_rdata0", rdata0, 8'hA5);
        chk("post_rst_read_rvalid1", rvalid1, 0);

        // Requester 1 takes ownership with lock1 set, then both contend.
        next_cycle(); lock1 = 1'b1; drive(0,0,0,0, 1,0,8'h50,0);
        @(negedge clk); chk("lock_first_gnt1", gnt1, 1);
        for (int i = 0; i < 8; i++) begin
            next_cycle(); drive(1,0,8'h40,0, 1,0,8'h50,0);
            @(negedge clk);
`ifdef MEM_ARB_LOCK_EN
            chk($sformatf("lock%0d_gnt0", i), gnt0, 0);
            chk($sformatf("lock%0d_gnt1", i), gnt1, 1);
`else
            chk($sformatf("nolock%0d_gnt0", i), gnt0, (i != 4));
            chk($sformatf("nolock%0d_gnt1", i), gnt1, (i == 4));
`endif
        end
        next_cycle(); lock1 = 1'b0;
        @(negedge clk);
        chk("unlock_gnt0", gnt0, 1);
        chk("unlock_gnt1", gnt1, 0);
        next_cycle(); drive(0,0,0,0, 0,0,0,0);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port program/data memory between two requesters: requester 0 is the CPU fetch/operand path, requester 1 is the loader/debug port.
- Accepts one command per cycle, registers it onto the memory command bus, and tracks outstanding reads so each read result returns to the requester that issued it.
- Sits between the CPU datapath (PC/IR/ACC sequencing by the controller) and the memory macro.

Parameters:
- AW, 8, memory address width
- DW, 8, memory data width
- RD_LAT, 2, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..4
- BURST_MAX, 4, maximum consecutive contended grants to requester 0 before requester 1 is served; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- CLB  in  1  asynchronous active-low reset (clear)
- req0  in  1  requester 0 command request
- we0  in  1  requester 0 write enable (1 = write, 0 = read)
- addr0  in  AW  requester 0 address
- wdata0  in  DW  requester 0 write data
- gnt0  out  1  requester 0 command accepted this cycle
- rvalid0  out  1  read data valid for requester 0
- rdata0  out  DW  read data for requester 0
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as requester 0, for requester 1
- lock1  in  1  requester 1 bus lock (used only with the optional feature)
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after a read strobe

Behaviour:
- Single clock clk; reset CLB asynchronous, active-low.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid0=rvalid1=0, rdata0=rdata1=0, gnt0=gnt1=0 while CLB low. Internal state is last_owner=0, burst_cnt=0, read tag pipeline cleared.
- Grant logic: gnt0/gnt1 are combinational from req0/req1/last_owner/burst_cnt. At most one is high. A command transfers on a rising edge where reqN & gntN. Requesters hold req/we/addr/wdata stable until granted.
- Priority rules:
  - only req0 -> gnt0
  - only req1 -> gnt1
  - both requesting -> gnt1 if burst_cnt==BURST_MAX, else gnt0
  - neither -> no grant
- burst_cnt:
  - +1 on each gnt0 transfer while req1 is high, saturating at BURST_MAX
  - cleared to 0 on any gnt1 transfer
  - cleared to 0 on any cycle with req1 low
- last_owner is updated to the granted index on each transfer.
- Command path:
  - A transfer at edge k drives mem_en=1 and mem_we/mem_addr/mem_wdata from the granted requester during cycle k+1.
  - mem_en=0 in any cycle following an edge with no transfer. mem_addr and mem_wdata hold their last values when idle.
- Read return:
  - A read strobe (mem_en=1, mem_we=0) in cycle k+1 pushes the requester ID into a tag shift register RD_LAT deep.
  - In cycle k+1+RD_LAT, rvalidN=1 for the tagged requester and rdataN=mem_rdata.
  - Non-tagged rvalid=0; rdata of a non-valid port is 0.
  - Writes produce no rvalid.
- Throughput: back-to-back transfers every cycle, including alternating requesters. Up to RD_LAT reads are outstanding; returns are in issue order.
- Ordering: a read issued after a write to the same address returns the new data. This follows from in-order issue through the single port.
- Reset mid-operation: CLB low clears the tag pipeline. No rvalid is asserted after reset release for reads issued before reset.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - While lock1=1 and last_owner==1, gnt0 is forced 0 and requester 1 is granted whenever req1 is high, ignoring burst_cnt.
  - Dropping lock1 returns to normal rules the next cycle.
  - burst_cnt stays 0 while the lock is held.
- Not defined: lock1 is ignored and priority rules apply unconditionally.

Test Plan:
- Reset then req0 read addr 0x10, memory returns 0xA5 -> gnt0 same cycle, mem_en/mem_addr=0x10 next cycle, rvalid0=1 with rdata0=0xA5 exactly 3 cycles after transfer edge (RD_LAT=2), rvalid1 stays 0.
- req0 and req1 held continuously (both reads) -> grant sequence 0,0,0,0,1,0,0,0,0,1...; rvalid tags match the grant sequence with 2-cycle offset.
- req1 write 0x3C to 0x20, then req0 read 0x20 next cycle -> mem sees write then read in consecutive cycles; rvalid0 data 0x3C.
- Alternating single-cycle reads req0 @0x01, req1 @0x02, req0 @0x03 -> rvalid0, rvalid1, rvalid0 in consecutive cycles with matching data; no dropped or swapped returns.
- Two reads outstanding, CLB pulsed low -> all outputs 0 immediately; no rvalid after release until new reads are issued.
- With MEM_ARB_LOCK_EN: req1 with lock1=1 for 8 cycles while req0 high -> gnt1 for all 8, gnt0=0; lock1 dropped -> gnt0 next cycle.
